// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave between data and inst masters; data has priority. An in-order owner FIFO routes each data_ok back to its master.
// Latency: zero added cycles; addr_ok and data_ok are routed combinationally.
// Backpressure: s_req is held low while DEPTH transactions are outstanding, and a request that is not yet accepted stays locked to its master.
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] owner_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             lock;
  logic             lock_owner;

  logic gnt_vld;
  logic gnt_data;
  logic gnt_req;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head_owner;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_data = 1'b0;
    if (lock) begin
      gnt_vld  = 1'b1;
      gnt_data = lock_owner;
    end else begin
      gnt_vld  = d_req | i_req;
      gnt_data = d_req;
    end
  end

  assign gnt_req = gnt_data ? d_req : i_req;
  assign s_req   = resetn & gnt_vld & gnt_req & ~full;

  // With no grant, gnt_data is 0, so the inst fields drive the slave.
  assign s_wr    = gnt_data ? d_wr    : i_wr;
  assign s_size  = gnt_data ? d_size  : i_size;
  assign s_wstrb = gnt_data ? d_wstrb : i_wstrb;
  assign s_addr  = gnt_data ? d_addr  : i_addr;
  assign s_wdata = gnt_data ? d_wdata : i_wdata;

  assign push       = s_req & s_addr_ok;
  assign pop        = resetn & s_data_ok & ~empty;
  assign head_owner = owner_q[rd_ptr];

  assign d_addr_ok = push & gnt_data;
  assign i_addr_ok = push & ~gnt_data;
  assign d_data_ok = pop & head_owner;
  assign i_data_ok = pop & ~head_owner;
  assign d_rdata   = s_rdata;
  assign i_rdata   = s_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
    end else if (s_req && !s_addr_ok) begin
      lock       <= 1'b1;
      lock_owner <= gnt_data;
    end else if (push) begin
      lock <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= gnt_data;
        wr_ptr          <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: cycle table, directed lock/full/reset sequences, randomized run against a queue model.
module tb_sram_like_arbiter;

  localparam int DEPTH = 4;
  localparam logic [31:0] DA = 32'hA000_0000;
  localparam logic [31:0] IA = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        d_req, d_wr, i_req, i_wr;
  logic [1:0]  d_size, i_size;
  logic [3:0]  d_wstrb, i_wstrb;
  logic [31:0] d_addr, d_wdata, i_addr, i_wdata;
  logic        d_addr_ok, d_data_ok, i_addr_ok, i_data_ok;
  logic [31:0] d_rdata, i_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        d_req, i_req, aok, dok;
    logic [31:0] rdata;
    logic        e_sreq, e_daok, e_iaok, e_ddok, e_idok;
    logic [31:0] e_saddr;
  } vec_t;

  vec_t tbl [12];

  // Reference model: queue of owners (1 = data) and the master whose request is pending.
  bit m_q[$];
  int m_held;
  int gnt;
  logic greq, e_sreq, acc, mpop, head;
  logic [71:0] e_pay;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic d, input logic i, input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    d_req = d; i_req = i; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    d_addr = DA; i_addr = IA;
    #1;
  endtask

  task automatic chk_outs(input string nm, input logic sr, input logic da, input logic ia,
                          input logic dd, input logic id);
    chk({nm, ".s_req"}, 72'(s_req), 72'(sr));
    chk({nm, ".d_addr_ok"}, 72'(d_addr_ok), 72'(da));
    chk({nm, ".i_addr_ok"}, 72'(i_addr_ok), 72'(ia));
    chk({nm, ".d_data_ok"}, 72'(d_data_ok), 72'(dd));
    chk({nm, ".i_data_ok"}, 72'(i_data_ok), 72'(id));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    d_req = 1'b0; i_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    //           d  i  aok dok rdata         sreq da ia dd id  saddr
    tbl[0]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, IA};
    tbl[1]  = '{0, 0, 0, 1, 32'h5,        0, 0, 0, 0, 0, IA};
    tbl[2]  = '{0, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, IA};
    tbl[3]  = '{1, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, DA};
    tbl[4]  = '{0, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, IA};
    tbl[5]  = '{0, 0, 0, 1, 32'h1,        0, 0, 0, 0, 1, IA};
    tbl[6]  = '{0, 0, 0, 1, 32'h2,        0, 0, 0, 1, 0, IA};
    tbl[7]  = '{0, 0, 0, 1, 32'h3,        0, 0, 0, 0, 1, IA};
    tbl[8]  = '{1, 1, 1, 0, 32'h0,        1, 1, 0, 0, 0, DA};
    tbl[9]  = '{1, 1, 1, 1, 32'hDEADBEEF, 1, 1, 0, 1, 0, DA};
    tbl[10] = '{0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 1, 0, IA};
    tbl[11] = '{0, 0, 0, 1, 32'h7,        0, 0, 0, 0, 0, IA};

    resetn = 1'b0;
    d_req = 1'b1; i_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = '0;
    d_wr = 1'b0; d_size = 2'd2; d_wstrb = 4'hF; d_addr = DA; d_wdata = 32'h1111_1111;
    i_wr = 1'b0; i_size = 2'd2; i_wstrb = 4'hF; i_addr = IA; i_wdata = 32'h2222_2222;
    #12;
    chk_outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    d_req = 1'b0; i_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;

    for (int k = 0; k < 12; k++) begin
      cyc(tbl[k].d_req, tbl[k].i_req, tbl[k].aok, tbl[k].dok, tbl[k].rdata);
      chk_outs($sformatf("tbl%0d", k), tbl[k].e_sreq, tbl[k].e_daok, tbl[k].e_iaok,
               tbl[k].e_ddok, tbl[k].e_idok);
      chk($sformatf("tbl%0d.s_addr", k), 72'(s_addr), 72'(tbl[k].e_saddr));
      if (tbl[k].e_ddok) chk($sformatf("tbl%0d.d_rdata", k), 72'(d_rdata), 72'(tbl[k].rdata));
      if (tbl[k].e_idok) chk($sformatf("tbl%0d.i_rdata", k), 72'(i_rdata), 72'(tbl[k].rdata));
    end

    // Lock: inst request stalls, data arrives mid-stall, inst must stay presented.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 0);
      chk_outs("lock_wait", 1, 0, 0, 0, 0);
      chk("lock_wait.s_addr", 72'(s_addr), 72'(IA));
    end
    cyc(1, 1, 0, 0, 0);
    chk_outs("lock_drise", 1, 0, 0, 0, 0);
    chk("lock_drise.s_addr", 72'(s_addr), 72'(IA));
    cyc(1, 1, 1, 0, 0);
    chk_outs("lock_accept", 1, 0, 1, 0, 0);
    chk("lock_accept.s_addr", 72'(s_addr), 72'(IA));
    cyc(1, 0, 1, 0, 0);
    chk_outs("lock_next", 1, 1, 0, 0, 0);
    chk("lock_next.s_addr", 72'(s_addr), 72'(DA));
    cyc(0, 0, 0, 1, 32'h11);
    chk_outs("lock_rsp0", 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h22);
    chk_outs("lock_rsp1", 0, 0, 0, 1, 0);

    // Full: four accepts, then a fifth request is held off until a pop lands.
    for (int k = 0; k < DEPTH; k++) begin
      cyc(1, 0, 1, 0, 0);
      chk_outs("fill", 1, 1, 0, 0, 0);
    end
    cyc(1, 0, 1, 0, 0);
    chk_outs("full_block", 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 32'h33);
    chk_outs("full_pop", 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    chk_outs("full_reopen", 1, 1, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) begin
      cyc(0, 0, 0, 1, 32'h44);
      chk_outs("full_drain", 0, 0, 0, 1, 0);
    end

    // Reset with two outstanding: ownership is discarded.
    cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    @(negedge clk);
    d_req = 1'b1; i_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
    resetn = 1'b0;
    #1;
    chk_outs("rst_mid", 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    d_req = 1'b0; i_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    #1;
    chk_outs("rst_after", 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk_outs("rst_newreq", 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 32'h55);
    chk_outs("rst_newrsp", 0, 0, 0, 0, 1);

    // Randomized run against the queue model.
    do_reset();
    m_q.delete();
    m_held = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (m_held != 1) begin
        d_req = ($urandom_range(0, 9) < 4); d_wr = 1'($urandom); d_size = 2'($urandom_range(0, 2));
        d_wstrb = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      if (m_held != 0) begin
        i_req = ($urandom_range(0, 9) < 5); i_wr = 1'($urandom); i_size = 2'($urandom_range(0, 2));
        i_wstrb = 4'($urandom); i_addr = $urandom; i_wdata = $urandom;
      end
      s_addr_ok = ($urandom_range(0, 9) < 6);
      s_data_ok = ($urandom_range(0, 9) < 3);
      s_rdata = $urandom;
      #1;
      gnt    = (m_held >= 0) ? m_held : (d_req ? 1 : (i_req ? 0 : -1));
      greq   = (gnt == 1) ? d_req : ((gnt == 0) ? i_req : 1'b0);
      e_sreq = greq && (m_q.size() < DEPTH);
      acc    = e_sreq && s_addr_ok;
      mpop   = s_data_ok && (m_q.size() > 0);
      head   = mpop ? m_q[0] : 1'b0;
      e_pay  = (gnt == 1) ? 72'({d_wr, d_size, d_wstrb, d_addr, d_wdata})
                          : 72'({i_wr, i_size, i_wstrb, i_addr, i_wdata});
      chk_outs("rnd", e_sreq, acc && gnt == 1, acc && gnt == 0, mpop && head, mpop && !head);
      chk("rnd.payload", 72'({s_wr, s_size, s_wstrb, s_addr, s_wdata}), e_pay);
      chk("rnd.rdata", 72'({d_rdata, i_rdata}), 72'({s_rdata, s_rdata}));
      if (mpop) void'(m_q.pop_front());
      if (acc) m_q.push_back(gnt == 1);
      if (e_sreq && !s_addr_ok) m_held = gnt;
      else if (acc) m_held = -1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like slave port (addr_ok/data_ok split handshake) between the data-side and inst-side sram-like masters of cpu_sram.
- Sits between cpu_sram and cpu_axi_interface; the bridge then sees a single requester.
- Fixed priority: data over inst. Requests are tracked in an in-order owner FIFO so each slave data_ok is routed back to the master that issued it.

Parameters:
- DEPTH, 4, maximum outstanding accepted-but-not-completed transactions; must be ≥1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter; derived, do not override.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- d_req/i_req  in  1  master request (data/inst)
- d_wr/i_wr  in  1  write enable
- d_size/i_size  in  2  0=byte, 1=half, 2=word
- d_wstrb/i_wstrb  in  4  byte strobes
- d_addr/i_addr  in  32  address
- d_wdata/i_wdata  in  32  write data
- d_addr_ok/i_addr_ok  out  1  request accepted
- d_data_ok/i_data_ok  out  1  response for this master's oldest outstanding transaction
- d_rdata/i_rdata  out  32  read data; valid with data_ok
- s_req, s_wr, s_size[2], s_wstrb[4], s_addr[32], s_wdata[32]  out  muxed request to slave
- s_addr_ok  in  1  slave accepted request
- s_data_ok  in  1  slave completed oldest transaction
- s_rdata  in  32  slave read data

Behaviour:
- Reset (resetn=0, async): owner FIFO emptied, count=0, rd/wr pointers=0, lock=0, lock_owner=0.
  - While resetn=0: s_req, d_addr_ok, i_addr_ok, d_data_ok and i_data_ok are all forced 0.
- Reset mid-operation discards all outstanding ownership. The slave must be reset together with this block.
- full = (count==DEPTH); empty = (count==0).
- Grant (combinational):
  - lock=1: grant = lock_owner.
  - Otherwise: data if d_req; else inst if i_req; else none.
- s_req = granted master's req && !full. s_wr/s_size/s_wstrb/s_addr/s_wdata mux from the granted master. When there is no grant, these fields drive the inst master's fields.
- Lock:
  - Set, with lock_owner = grant, when s_req && !s_addr_ok.
  - Cleared on a cycle with s_req && s_addr_ok.
  - Guarantees a request presented to the slave stays stable until accepted, even if the other master raises req.
  - A master deasserting req while locked is a protocol violation and its behaviour is undefined.
- Acceptance: x_addr_ok = s_addr_ok && s_req && (grant==x). Same cycle, zero added latency.
- Push:
  - On s_req && s_addr_ok, write the owner bit (1=data, 0=inst) at wr_ptr; wr_ptr wraps modulo DEPTH.
  - No push can happen when full, because s_req is 0.
- Pop:
  - On s_data_ok && !empty: owner = fifo[rd_ptr]; d_data_ok = s_data_ok && owner; i_data_ok = s_data_ok && !owner; rd_ptr wraps modulo DEPTH.
  - Same-cycle, combinational routing; zero added latency.
- d_rdata = i_rdata = s_rdata (broadcast); only the data_ok qualifies validity.
- Simultaneous push and pop: count unchanged, both pointers advance. A pop while full frees a slot from the next cycle onward, not the same cycle.
- s_data_ok while empty: ignored. No pop, neither data_ok asserted, count stays 0.
- Same-cycle return: a response is never returned in the cycle its request is accepted. The FIFO is written at the clock edge.
- Count arithmetic: count_next = count + push - pop, CNT_W bits; never exceeds DEPTH and never goes below 0.

Test Plan:
- Both d_req=1 and i_req=1, s_addr_ok=1 every cycle, s_data_ok one cycle after each acceptance:
  - data is granted every cycle and inst starves; d_addr_ok=1 and i_addr_ok=0.
  - Each d_data_ok returns the matching s_rdata, e.g. 0xDEADBEEF.
- Inst request at 0xBFC00000 with s_addr_ok held 0 for 3 cycles, then d_req rises:
  - s_addr stays 0xBFC00000 (locked) until s_addr_ok.
  - i_addr_ok pulses once; data is granted on the next cycle.
- Interleaving: accept inst, data, inst; then s_data_ok three times with rdata 0x1, 0x2, 0x3:
  - i_data_ok with 0x1, then d_data_ok with 0x2, then i_data_ok with 0x3.
- DEPTH=4, 4 accepted with no data_ok:
  - 5th req sees s_req=0 and addr_ok=0.
  - One s_data_ok: count=3; s_req reasserts the next cycle.
  - Pointer wrap verified over 10 further transactions.
- Full FIFO with push attempted while s_data_ok pops same cycle: no push that cycle, count 4→3.
- Spurious s_data_ok while empty: no data_ok output and count stays 0. resetn pulled low with 2 outstanding: all outputs 0 immediately; after release count=0 and the first new s_data_ok is ignored.
